// File: rtl/pedestal_restore_module.sv
// rtl/pedestal_restore_module.sv - slewed baseline subtraction for one ADC channel
//
// Purpose:
//   Accepts baseline estimates from the block averager and moves the applied
//   baseline toward each new estimate in small, evenly spaced steps. The
//   applied baseline is subtracted from the live ADC stream with saturation.
//
// Ports:
//   clk              in   1   clock, rising edge
//   reset            in   1   synchronous, active-high reset
//   enable           in   1   1: y carries restored data, 0: y forced to 0
//   x                in  16   signed raw ADC sample, one per clock
//   baseline_in      in  16   signed baseline estimate
//   baseline_valid   in   1   one-cycle strobe qualifying baseline_in
//   hold             in   1   trigger veto, freezes baseline tracking
//   y                out 16   signed pedestal-restored sample (2-clock latency)
//   baseline_applied out 16   signed baseline currently subtracted
//   slewing          out  1   high while the applied baseline is moving
//   locked           out  1   high once the first estimate has been accepted

module pedestal_restore_module #(
  parameter int SLEW_SHIFT = 4,
  parameter int STEP       = 1,
  parameter int DEADBAND   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] x,
  input  logic signed [15:0] baseline_in,
  input  logic               baseline_valid,
  input  logic               hold,
  output logic signed [15:0] y,
  output logic signed [15:0] baseline_applied,
  output logic               slewing,
  output logic               locked
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SLEW = 1'b1;

  localparam logic [SLEW_SHIFT-1:0] TICK_LAST  = '1;
  localparam logic [16:0]           STEP17     = 17'(STEP);
  localparam logic [16:0]           DEADBAND17 = 17'(DEADBAND);

  logic [0:0]            state;
  logic [SLEW_SHIFT-1:0] tick_cnt;
  logic signed [15:0]    target;
  logic signed [15:0]    pending;
  logic                  pending_flag;
  logic signed [15:0]    x_r;

  // Effective update: a live strobe wins over a value parked during hold.
  logic               eff;
  logic signed [15:0] eff_value;

  // All baseline differences use 17 bits so extreme baselines never wrap.
  logic signed [16:0] applied_ext;
  logic signed [16:0] diff_eff;
  logic signed [16:0] diff_tgt;
  logic [16:0]        abs_eff;
  logic [16:0]        abs_tgt;
  logic signed [16:0] applied_moved;
  logic               tick;

  logic signed [16:0] d;
  logic signed [15:0] d_sat;

  always_comb begin
    eff       = !hold && (baseline_valid || pending_flag);
    eff_value = baseline_valid ? baseline_in : pending;

    applied_ext = {baseline_applied[15], baseline_applied};
    diff_eff    = {eff_value[15], eff_value} - applied_ext;
    diff_tgt    = {target[15], target} - applied_ext;
    abs_eff     = diff_eff[16] ? (~diff_eff + 17'sd1) : diff_eff;
    abs_tgt     = diff_tgt[16] ? (~diff_tgt + 17'sd1) : diff_tgt;

    // Only used when |target - applied| > STEP, so the move never overshoots.
    applied_moved = diff_tgt[16] ? (applied_ext - $signed(STEP17))
                                 : (applied_ext + $signed(STEP17));

    tick = (state == ST_SLEW) && (tick_cnt == TICK_LAST);
  end

  // Restoration datapath: subtract the baseline held this cycle, then clamp.
  always_comb begin
    d = {x_r[15], x_r} - applied_ext;
    if (d[16] != d[15]) begin
      d_sat = d[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      d_sat = d[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_r              <= '0;
      y                <= '0;
      baseline_applied <= '0;
      target           <= '0;
      pending          <= '0;
      pending_flag     <= 1'b0;
      locked           <= 1'b0;
      tick_cnt         <= '0;
      state            <= ST_IDLE;
    end else begin
      x_r <= x;
      y   <= enable ? d_sat : 16'sd0;

      if (hold) begin
        // Tracking frozen; park the newest estimate for release.
        if (baseline_valid) begin
          pending      <= baseline_in;
          pending_flag <= 1'b1;
        end
      end else begin
        pending_flag <= 1'b0;

        if (!locked) begin
          // Acquisition: first estimate is applied directly, no slew.
          if (eff) begin
            baseline_applied <= eff_value;
            target           <= eff_value;
            locked           <= 1'b1;
          end
        end else if (state == ST_IDLE) begin
          if (eff && (abs_eff > DEADBAND17)) begin
            target   <= eff_value;
            tick_cnt <= '0;
            state    <= ST_SLEW;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;

          // Tick is judged against the target held before this cycle's update.
          if (tick) begin
            if (abs_tgt <= STEP17) begin
              baseline_applied <= target;
              state            <= ST_IDLE;
            end else begin
              baseline_applied <= applied_moved[15:0];
            end
          end

          // Retarget mid-slew keeps the tick phase and skips the deadband.
          if (eff) begin
            target <= eff_value;
          end
        end
      end
    end
  end

  assign slewing = (state == ST_SLEW);

endmodule

// File: tb/tb_pedestal_restore_module.sv
// tb/tb_pedestal_restore_module.sv - randomized self-checking bench for pedestal_restore_module

module tb_pedestal_restore_module;

  localparam int SLEW_SHIFT = 4;
  localparam int STEP       = 1;
  localparam int DEADBAND   = 2;
  localparam int PERIOD     = 1 << SLEW_SHIFT;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [15:0] x;
  logic signed [15:0] baseline_in;
  logic               baseline_valid;
  logic               hold;
  logic signed [15:0] y;
  logic signed [15:0] baseline_applied;
  logic               slewing;
  logic               locked;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pedestal_restore_module #(
    .SLEW_SHIFT(SLEW_SHIFT),
    .STEP(STEP),
    .DEADBAND(DEADBAND)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .x(x),
    .baseline_in(baseline_in),
    .baseline_valid(baseline_valid),
    .hold(hold),
    .y(y),
    .baseline_applied(baseline_applied),
    .slewing(slewing),
    .locked(locked)
  );

  // Reference model: plain integers, slew phase counted as cycles spent slewing.
  int m_xr, m_y, m_applied, m_target, m_pend, m_n;
  bit m_pflag, m_locked, m_slew;

  function automatic int abs_i(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    bit has;
    int v;
    if (reset) begin
      m_xr = 0; m_y = 0; m_applied = 0; m_target = 0; m_pend = 0;
      m_n = 0; m_pflag = 0; m_locked = 0; m_slew = 0;
    end else begin
      m_y  = enable ? clamp16(m_xr - m_applied) : 0;
      m_xr = int'(x);
      if (hold) begin
        if (baseline_valid) begin
          m_pend  = int'(baseline_in);
          m_pflag = 1;
        end
      end else begin
        has     = baseline_valid || m_pflag;
        v       = baseline_valid ? int'(baseline_in) : m_pend;
        m_pflag = 0;
        if (!m_locked) begin
          if (has) begin
            m_applied = v;
            m_target  = v;
            m_locked  = 1;
          end
        end else if (!m_slew) begin
          if (has && abs_i(v - m_applied) > DEADBAND) begin
            m_target = v;
            m_n      = 0;
            m_slew   = 1;
          end
        end else begin
          m_n++;
          if (m_n % PERIOD == 0) begin
            if (abs_i(m_target - m_applied) <= STEP) begin
              m_applied = m_target;
              m_slew    = 0;
            end else begin
              m_applied += (m_target > m_applied) ? STEP : -STEP;
            end
          end
          if (has) m_target = v;
        end
      end
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      check("y", int'(y), m_y);
      check("applied", int'(baseline_applied), m_applied);
      check("slewing", int'(slewing), int'(m_slew));
      check("locked", int'(locked), int'(m_locked));
    end
  endtask

  task automatic strobe(int v);
    baseline_in    = 16'(v);
    baseline_valid = 1'b1;
    run(1);
    baseline_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; x = '0; baseline_in = '0;
    baseline_valid = 1'b0; hold = 1'b0;
    run(2);
    check("rst_y", int'(y), 0);
    check("rst_applied", int'(baseline_applied), 0);
    check("rst_locked", int'(locked), 0);
    reset = 1'b0;

    // Acquisition and basic restoration
    strobe(1000);
    check("acq_applied", int'(baseline_applied), 1000);
    check("acq_locked", int'(locked), 1);
    x = 16'sd1500;
    run(2);
    check("y_500", int'(y), 500);
    enable = 1'b0;
    run(1);
    check("y_disabled", int'(y), 0);
    enable = 1'b1;

    // Slew +10 at one LSB per 16 cycles
    strobe(1010);
    check("slew_start", int'(slewing), 1);
    run(159);
    check("slew_159", int'(baseline_applied), 1009);
    check("slew_159_s", int'(slewing), 1);
    run(1);
    check("slew_160", int'(baseline_applied), 1010);
    check("slew_end", int'(slewing), 0);
    strobe(1012);
    check("deadband", int'(slewing), 0);

    // Saturation in both directions
    do_reset();
    x = 16'sd32767;
    strobe(-1000);
    run(2);
    check("sat_pos", int'(y), 32767);
    do_reset();
    x = -16'sd32768;
    strobe(1000);
    run(2);
    check("sat_neg", int'(y), -32768);

    // Hold parks the newest estimate, release starts slewing to it
    do_reset();
    x = 16'sd0;
    strobe(1000);
    hold = 1'b1;
    strobe(900);
    run(1);
    strobe(950);
    run(3);
    check("hold_applied", int'(baseline_applied), 1000);
    check("hold_slew", int'(slewing), 0);
    hold = 1'b0;
    run(1);
    check("release_slew", int'(slewing), 1);
    run(799);
    check("release_799", int'(baseline_applied), 951);
    run(1);
    check("release_800", int'(baseline_applied), 950);
    check("release_done", int'(slewing), 0);

    // Live strobe on release beats pending; mid-slew retarget keeps phase
    do_reset();
    strobe(1000);
    hold = 1'b1;
    strobe(950);
    run(1);
    hold = 1'b0;
    strobe(1100);
    check("live_wins", int'(slewing), 1);
    run(20);
    check("phase_20", int'(baseline_applied), 1001);
    strobe(1050);
    run(10);
    check("phase_31", int'(baseline_applied), 1001);
    run(1);
    check("phase_32", int'(baseline_applied), 1002);

    // Reset mid-slew, then direct reload
    do_reset();
    check("midrst_applied", int'(baseline_applied), 0);
    check("midrst_y", int'(y), 0);
    check("midrst_slew", int'(slewing), 0);
    check("midrst_locked", int'(locked), 0);
    strobe(200);
    check("reload_applied", int'(baseline_applied), 200);
    check("reload_locked", int'(locked), 1);

    // Randomized run against the model
    for (int i = 0; i < 6000; i++) begin
      int b;
      reset = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      x = 16'($urandom);
      baseline_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) b = int'($signed(16'($urandom)));
      else b = clamp16(m_applied + int'($urandom_range(0, 60)) - 30);
      baseline_in = 16'(b);
      run(1);
    end
    reset = 1'b0;
    baseline_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
